// File: rtl/lsu_ctrl_if.sv
// Execute/writeback/data_mem bus of the load/store control stage.
// The slave modport is the LSU's view; master is the surrounding pipeline and memory.
interface lsu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [4:0]       req_rd;

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             mem_wr_en;
    logic [2:0]       mem_funct3;
    logic [WIDTH-1:0] mem_rdata;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic [4:0]       resp_rd;
    logic [1:0]       resp_err;

    logic             busy;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_rdata, resp_ready,
        output req_ready, mem_addr, mem_data, mem_wr_en, mem_funct3,
        output resp_valid, resp_data, resp_rd, resp_err, busy
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_rdata, resp_ready,
        input  req_ready, mem_addr, mem_data, mem_wr_en, mem_funct3,
        input  resp_valid, resp_data, resp_rd, resp_err, busy
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request at a time, one data_mem access cycle, registered response.
// Optional upper-address access-fault check enabled by defining LSU_BOUNDS_CHECK_EN.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// ACCESS | one cycle driving data_mem; memory acts on the falling edge
// RESP   | resp_valid=1, response held until resp_ready
module lsu_ctrl #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 12
) (
    input logic        clk,
    input logic        rst,
    lsu_ctrl_if.slave  bus
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] mem_data_q;
    logic [2:0]       mem_funct3_q;
    logic             mem_wr_en_q;
    logic             we_q;
    logic [4:0]       rd_q;
    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [4:0]       resp_rd_q;
    logic [1:0]       resp_err_q;

    logic misaligned;
    logic illegal;
    logic out_of_range;

    assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));

    assign illegal = bus.req_we ? (bus.req_funct3 > 3'b010)
                                : ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                                   (bus.req_funct3 == 3'b111));

    // Constant-folds away when the bounds check is not built in.
    assign out_of_range = BOUNDS_EN && ((bus.req_addr & HI_MASK) != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_funct3_q <= 3'b000;
            mem_wr_en_q  <= 1'b0;
            we_q         <= 1'b0;
            rd_q         <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= 5'd0;
            resp_err_q   <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q <= bus.req_we;
                        rd_q <= bus.req_rd;
                        if (misaligned || illegal) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                            resp_rd_q    <= bus.req_rd;
                            resp_err_q   <= bus.req_we ? 2'b10 : 2'b01;
                        end else if (out_of_range) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                            resp_rd_q    <= bus.req_rd;
                            resp_err_q   <= 2'b11;
                        end else begin
                            state        <= ACCESS;
                            mem_addr_q   <= bus.req_addr;
                            mem_data_q   <= bus.req_wdata;
                            mem_funct3_q <= bus.req_funct3;
                            mem_wr_en_q  <= bus.req_we;
                        end
                    end
                end
                ACCESS: begin
                    // mem_addr/data/funct3 keep their values so nothing glitches after the access.
                    state        <= RESP;
                    mem_wr_en_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= we_q ? '0 : bus.mem_rdata;
                    resp_rd_q    <= rd_q;
                    resp_err_q   <= 2'b00;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_wr_en_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.mem_funct3 = mem_funct3_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan cases plus random requests against a byte-level reference memory.
// Includes a falling-edge data_mem model; honours LSU_BOUNDS_CHECK_EN in its expectations.
module tb_lsu_ctrl;

    logic clk;
    logic rst;

    lsu_ctrl_if #(.WIDTH(32)) bus ();

    lsu_ctrl #(.WIDTH(32), .ADDR_BITS(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // data_mem: word array, acts on the falling edge
    logic [31:0] mem_w [0:1023];
    logic [9:0]  dm_idx;
    int          dm_lane;
    logic [31:0] dm_sh;

    always @(negedge clk) begin
        dm_idx  = bus.mem_addr[11:2];
        dm_lane = int'(bus.mem_addr[1:0]);
        if (bus.mem_wr_en) begin
            wr_cnt++;
            case (bus.mem_funct3)
                3'b000: mem_w[dm_idx][8*dm_lane +: 8] = bus.mem_data[7:0];
                3'b001: if (dm_lane <= 2) mem_w[dm_idx][8*dm_lane +: 16] = bus.mem_data[15:0];
                3'b010: mem_w[dm_idx] = bus.mem_data;
                default: ;
            endcase
        end
        dm_sh = mem_w[dm_idx] >> (8 * dm_lane);
        case (bus.mem_funct3)
            3'b000:  bus.mem_rdata = {{24{dm_sh[7]}}, dm_sh[7:0]};
            3'b001:  bus.mem_rdata = {{16{dm_sh[15]}}, dm_sh[15:0]};
            3'b100:  bus.mem_rdata = {24'h0, dm_sh[7:0]};
            3'b101:  bus.mem_rdata = {16'h0, dm_sh[15:0]};
            default: bus.mem_rdata = mem_w[dm_idx];
        endcase
    end

    // Reference model: flat 4 KiB byte memory, upper address bits alias.
    logic [7:0] ref_mem [0:4095];

    function automatic logic [1:0] ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic mis;
        logic ill;
        mis = (f3 == 3'b001 || f3 == 3'b101) ? (a % 2 != 0) :
              (f3 == 3'b010)                 ? (a % 4 != 0) : 1'b0;
        ill = we ? !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
                 : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        if (mis || ill) return we ? 2'b10 : 2'b01;
`ifdef LSU_BOUNDS_CHECK_EN
        if (a >= 32'h1000) return 2'b11;
`endif
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int b;
        logic [31:0] v;
        b = int'(a % 4096);
        v = {ref_mem[(b+3)%4096], ref_mem[(b+2)%4096], ref_mem[(b+1)%4096], ref_mem[b]};
        case (f3)
            3'b000:  return (v[7]  ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF);
            3'b001:  return (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF);
            3'b010:  return v;
            3'b100:  return v & 32'hFF;
            3'b101:  return v & 32'hFFFF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int b;
        int n;
        b = int'(a % 4096);
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[(b+i)%4096] = 8'((d >> (8*i)) & 32'hFF);
    endtask

    task automatic drive_junk();
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom & 32'h3C;
        bus.req_wdata  = $urandom;
        bus.req_rd     = 5'($urandom_range(0, 31));
    endtask

    // One request end to end: latency, response fields, hold stability, write count, release.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd, input int hold);
        logic [1:0]  e_err;
        logic [31:0] e_data;
        int          e_lat;
        int          e_wr;
        int          lat;
        int          wr0;
        e_err  = ref_err(we, f3, a);
        e_data = (e_err == 2'b00 && !we) ? ref_load(f3, a) : 32'h0;
        e_lat  = (e_err == 2'b00) ? 2 : 1;
        e_wr   = (e_err == 2'b00 && we) ? 1 : 0;

        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_rd     = rd;
        bus.resp_ready = 1'b0;
        wr0 = wr_cnt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_data", bus.resp_data, e_data);
        chk("resp_rd", 32'(bus.resp_rd), 32'(rd));
        chk("resp_err", 32'(bus.resp_err), 32'(e_err));
        if (e_wr == 1) ref_store(f3, a, d);

        for (int h = 0; h < hold; h++) begin
            drive_junk();
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_data", bus.resp_data, e_data);
            chk("hold_rd", 32'(bus.resp_rd), 32'(rd));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_busy", 32'(bus.busy), 32'd1);
        end

        drive_junk();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        chk("release_valid", 32'(bus.resp_valid), 32'd0);
        chk("release_idle", 32'(bus.req_ready), 32'd1);
        chk("wr_en_cycles", 32'(wr_cnt - wr0), 32'(e_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] word20;

    initial begin
        for (int i = 0; i < 1024; i++) mem_w[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
        bus.mem_rdata  = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        bus.resp_ready = 1'b0;
        rst = 1'b0;
        #12;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_data", bus.mem_data, 32'h0);
        chk("rst_mem_funct3", 32'(bus.mem_funct3), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;

        // SW / LW round trip
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, 0);
        // SB then LB / LBU
        run_req(1'b1, 3'b000, 32'h13, 32'h80, 5'd3, 0);
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 0);
        run_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd5, 0);
        // Misaligned LW, misaligned SH leaving word 0x20 intact
        run_req(1'b1, 3'b010, 32'h20, 32'h11223344, 5'd6, 0);
        run_req(1'b0, 3'b010, 32'h12, 32'h0, 5'd7, 0);
        run_req(1'b1, 3'b001, 32'h21, 32'hAAAA5555, 5'd8, 0);
        word20 = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
        chk("word20_unchanged", mem_w[8], word20);
        // Response held off for 5 cycles with a competing request
        run_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd9, 5);

        // Reset pulse while a load is in ACCESS
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.req_rd     = 5'd10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd11, 0);

        // Upper address bits: alias to 0x0, or access fault when bounds check is built in
        run_req(1'b1, 3'b010, 32'h0, 32'h0BADF00D, 5'd12, 0);
        run_req(1'b0, 3'b010, 32'h1000, 32'h0, 5'd13, 0);
        run_req(1'b1, 3'b010, 32'h1004, 32'h12345678, 5'd14, 1);
        run_req(1'b0, 3'b010, 32'h4, 32'h0, 5'd15, 0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                    5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store control stage between the execute stage and data_mem. It accepts one memory request at a time through a valid/ready handshake and checks alignment and funct3 legality. It then drives data_mem's address, data, write-enable and funct3 for exactly one access cycle, captures the returned load data, and presents a registered response with an error code to writeback.

Parameters:
WIDTH, 32, data and address width.
ADDR_BITS, 12, implemented byte-address bits (1024 words x 4 bytes); used only by the optional bounds check.

Ports:
clk  input  1  clock; data_mem samples on the falling edge of this clock
rst  input  1  asynchronous reset, active-low
req_valid  input  1  request present from execute
req_ready  output  1  lsu can accept a request (state IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V load/store funct3
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, unaligned (byte/half in low bits)
req_rd  input  5  destination register tag, returned with the response
mem_addr  output  WIDTH  to data_mem mem_addr
mem_data  output  WIDTH  to data_mem mem_data
mem_wr_en  output  1  to data_mem wr_en
mem_funct3  output  3  to data_mem funct3
mem_rdata  input  WIDTH  from data_mem data_out
resp_valid  output  1  response available
resp_ready  input  1  writeback accepts response
resp_data  output  WIDTH  load result (0 for stores and errors)
resp_rd  output  5  tag of the completed request
resp_err  output  2  00 ok, 01 load misaligned/illegal, 10 store misaligned/illegal, 11 access fault
busy  output  1  high in any state other than IDLE; used as the pipeline stall

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (rst=0, asynchronous): state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, resp_err=00, mem_wr_en=0, mem_addr/mem_data/mem_funct3=0.
- req_ready = (state==IDLE). Handshake completes on the posedge with req_valid & req_ready; all req_* fields are registered at that edge.
- Legality check, evaluated on the request at acceptance:
  - Misaligned: funct3[1:0]=01 with addr[0]=1; funct3=010 with addr[1:0]!=00.
  - Illegal for loads: funct3 in {011,110,111}. Illegal for stores: funct3 not in {000,001,010}.
  - Misaligned or illegal -> next state RESP directly, with resp_err=01 (load) or 10 (store), resp_data=0. No ACCESS cycle; mem_wr_en is never asserted.
- Legal request -> ACCESS for exactly one cycle:
  - mem_addr, mem_data and mem_funct3 come from registers.
  - mem_wr_en = req_we, driven from registered state so it is stable across the falling edge.
  - data_mem performs the read or write on the falling edge within ACCESS.
  - On the ACCESS->RESP posedge, resp_data <= mem_rdata for a load, or 0 for a store. resp_err=00.
- RESP: resp_valid=1, and resp_data/rd/err are held stable until resp_ready=1. On that edge -> IDLE and resp_valid=0. No new request is accepted in the same cycle.
- Latency from acceptance edge to resp_valid: legal access 2 cycles, error 1 cycle. Throughput: at most one request per 3 cycles.
- Outside ACCESS: mem_wr_en=0. mem_addr holds its last value, so there are no spurious writes.
- resp_ready held low: remain in RESP indefinitely; busy=1.
- Reset asserted mid-ACCESS: a write in flight may or may not reach memory. After reset, state=IDLE and no response is emitted.

Optional Feature:
LSU_BOUNDS_CHECK_EN:
- Defined: a legal-alignment request with req_addr[WIDTH-1:ADDR_BITS] != 0 goes straight to RESP with resp_err=11 and no memory access. Alignment errors take priority over access fault.
- Undefined: upper address bits are ignored (memory aliases), and code 11 is never produced.

Test Plan:
- Reset, then SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 -> mem_wr_en high for one cycle only; load resp_data=0xDEADBEEF, resp_err=00, resp_valid 2 cycles after acceptance.
- SB 0x80 to addr 0x13, then LB addr=0x13 and LBU addr=0x13 -> resp_data 0xFFFFFF80 and 0x00000080.
- LW addr=0x12 -> resp_err=01 after 1 cycle, resp_data=0, mem_wr_en never high. SH addr=0x21 -> resp_err=10, and the memory word at 0x20 is unchanged.
- resp_ready held low for 5 cycles after a load -> resp_valid, resp_data and resp_rd stable; req_ready=0 and busy=1 throughout; a new req_valid is not accepted.
- rst pulsed low during ACCESS of a load -> resp_valid=0 and state IDLE immediately; the next request completes normally.
- With LSU_BOUNDS_CHECK_EN: LW addr=0x1000 -> resp_err=11, no access. Without it: the same LW returns the word stored at addr 0x0.
